// File: rtl/mux_nx1_reg_if.sv
// Handshake bundle for mux_nx1_reg: N valid/ready input channels and one
// registered valid/ready output channel, plus the selection controls.
interface mux_nx1_reg_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_nx1_reg.sv
// N-input registered multiplexer with valid/ready handshaking; selects either
// by explicit index or by round-robin arbitration among valid channels.
module mux_nx1_reg #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nx1_reg_if.slave  bus
);
    localparam logic [SELW:0]   N_W      = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_src_r;
    logic             out_valid_r;
    logic [SELW-1:0]  rr_ptr_r;

    logic             can_load_s;
    logic [SELW-1:0]  grant_s;
    logic             grant_any_s;
    logic [N-1:0]     ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [SELW-1:0]  rr_next_s;

    // Candidate channel: explicit select, or first valid index at/after rr_ptr, wrapping.
    always_comb begin
        grant_s     = {SELW{1'b0}};
        grant_any_s = 1'b0;
        if (bus.mode == 1'b0) begin
            grant_s     = bus.sel;
            grant_any_s = ({1'b0, bus.sel} < N_W);
        end else begin
            // First pass covers rr_ptr..N-1, second pass the wrapped part 0..rr_ptr-1.
            for (int i = 0; i < N; i++) begin
                grant_s     = (!grant_any_s && bus.in_valid[i] && (SELW'(i) >= rr_ptr_r))
                              ? SELW'(i) : grant_s;
                grant_any_s = grant_any_s | (bus.in_valid[i] && (SELW'(i) >= rr_ptr_r));
            end
            for (int i = 0; i < N; i++) begin
                grant_s     = (!grant_any_s && bus.in_valid[i]) ? SELW'(i) : grant_s;
                grant_any_s = grant_any_s | bus.in_valid[i];
            end
        end
    end

    // Ready fan-out, data steering and transfer detection for the granted channel.
    always_comb begin
        can_load_s   = !out_valid_r || bus.out_ready;
        ready_s      = {N{1'b0}};
        grant_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            ready_s[i]   = can_load_s && grant_any_s && (grant_s == SELW'(i));
            grant_data_s = (grant_s == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : grant_data_s;
        end
        xfer_s    = |(ready_s & bus.in_valid);
        rr_next_s = (grant_s == LAST_IDX) ? {SELW{1'b0}} : (grant_s + SELW'(1));
    end

    // Output register and round-robin pointer; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_src_r   <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
            rr_ptr_r    <= {SELW{1'b0}};
        end else begin
            if (xfer_s) begin
                out_data_r  <= grant_data_s;
                out_src_r   <= grant_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready && out_valid_r) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            // Only arbitration wins advance the pointer; explicit selects leave it alone.
            if (xfer_s && bus.mode) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: directed vector table on N=4 and N=3
// instances, then randomized traffic against a behavioural reference model.
module tb_mux_nx1_reg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nx1_reg_if #(.N(4), .WIDTH(32), .SELW(2)) if4 ();
    mux_nx1_reg_if #(.N(3), .WIDTH(32), .SELW(2)) if3 ();

    mux_nx1_reg #(.N(4), .WIDTH(32), .SELW(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_nx1_reg #(.N(3), .WIDTH(32), .SELW(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // Stimulus copies (index 0 = N=4 instance, 1 = N=3 instance)
    logic             v_mode [2];
    logic [1:0]       v_sel  [2];
    logic [3:0]       v_vld  [2];
    logic             v_ordy [2];
    logic [3:0][31:0] v_dat  [2];

    // Reference model state
    logic        m_ov  [2] = '{1'b0, 1'b0};
    logic [1:0]  m_src [2] = '{2'd0, 2'd0};
    logic [31:0] m_dat [2] = '{32'd0, 32'd0};
    int          m_ptr [2] = '{0, 0};

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          d;
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  x_rdy;
        logic        x_ov;
        logic [1:0]  x_src;
        logic [31:0] x_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit d, logic r, logic m, logic [1:0] s, logic [3:0] v,
                                logic [31:0] dt, logic o, logic [3:0] xr, logic xo,
                                logic [1:0] xs, logic [31:0] xd);
        vec_t t;
        t.d = d; t.rst_n = r; t.mode = m; t.sel = s; t.vld = v; t.dat = dt; t.ordy = o;
        t.x_rdy = xr; t.x_ov = xo; t.x_src = xs; t.x_dat = xd;
        return t;
    endfunction

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Which channel is offered service this cycle, and the resulting ready vector.
    task automatic model_sel(input int d, output int g, output logic [3:0] rdy);
        int  n;
        logic can;
        n   = nch(d);
        can = !m_ov[d] || v_ordy[d];
        g   = -1;
        if (!v_mode[d]) begin
            if (int'(v_sel[d]) < n) g = int'(v_sel[d]);
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[d] + k) % n;
                if (g < 0 && v_vld[d][c]) g = c;
            end
        end
        rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [3:0] rdy;
            model_sel(d, g, rdy);
            if (!rst_n) begin
                m_ov[d] = 1'b0; m_src[d] = 2'd0; m_dat[d] = 32'd0; m_ptr[d] = 0;
            end else if ((rdy & v_vld[d]) != 4'b0000) begin
                m_ov[d]  = 1'b1;
                m_src[d] = 2'(g);
                m_dat[d] = v_dat[d][g];
                if (v_mode[d]) m_ptr[d] = (g + 1) % nch(d);
            end else if (v_ordy[d] && m_ov[d]) begin
                m_ov[d] = 1'b0;
            end
        end
    endtask

    task automatic push();
        if4.mode = v_mode[0]; if4.sel = v_sel[0]; if4.in_valid = v_vld[0];
        if4.in_data = v_dat[0]; if4.out_ready = v_ordy[0];
        if3.mode = v_mode[1]; if3.sel = v_sel[1]; if3.in_valid = v_vld[1][2:0];
        if3.in_data = v_dat[1][2:0]; if3.out_ready = v_ordy[1];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic get_out(input int d, output logic [3:0] rdy, output logic ov,
                           output logic [1:0] src, output logic [31:0] dat);
        if (d == 0) begin
            rdy = if4.in_ready; ov = if4.out_valid; src = if4.out_src; dat = if4.out_data;
        end else begin
            rdy = {1'b0, if3.in_ready}; ov = if3.out_valid; src = if3.out_src; dat = if3.out_data;
        end
    endtask

    initial begin
        logic [3:0]  a_rdy;
        logic        a_ov;
        logic [1:0]  a_src;
        logic [31:0] a_dat;

        // Directed vectors: N=4 instance (d=0) then N=3 instance (d=1)
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0011, 1, 4'b0001, 1, 0, 32'h0000_0011));
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0022, 1, 4'b0010, 1, 1, 32'h0000_0022));
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0033, 1, 4'b0100, 1, 2, 32'h0000_0033));
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0044, 1, 4'b1000, 1, 3, 32'h0000_0044));
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0055, 1, 4'b0001, 1, 0, 32'h0000_0055));
        tbl.push_back(mk(0, 1, 1, 0, 4'hF, 32'h0000_0066, 1, 4'b0010, 1, 1, 32'h0000_0066));
        tbl.push_back(mk(0, 1, 1, 0, 4'h1, 32'h0000_0077, 1, 4'b0001, 1, 0, 32'h0000_0077));
        tbl.push_back(mk(0, 1, 1, 0, 4'hA, 32'h0000_0088, 1, 4'b0010, 1, 1, 32'h0000_0088));
        tbl.push_back(mk(0, 1, 1, 0, 4'hA, 32'h0000_0099, 1, 4'b1000, 1, 3, 32'h0000_0099));
        tbl.push_back(mk(0, 1, 1, 0, 4'hA, 32'h0000_00AA, 1, 4'b0010, 1, 1, 32'h0000_00AA));
        tbl.push_back(mk(0, 1, 1, 0, 4'hA, 32'h0000_00BB, 1, 4'b1000, 1, 3, 32'h0000_00BB));
        tbl.push_back(mk(0, 1, 1, 0, 4'h8, 32'h0000_00C1, 1, 4'b1000, 1, 3, 32'h0000_00C1));
        tbl.push_back(mk(0, 1, 1, 0, 4'h8, 32'h0000_00C2, 1, 4'b1000, 1, 3, 32'h0000_00C2));
        tbl.push_back(mk(0, 1, 1, 0, 4'h8, 32'h0000_00C3, 1, 4'b1000, 1, 3, 32'h0000_00C3));
        tbl.push_back(mk(0, 1, 0, 2, 4'hF, 32'hA5A5_0001, 1, 4'b0100, 1, 2, 32'hA5A5_0001));
        tbl.push_back(mk(0, 1, 0, 2, 4'hF, 32'hA5A5_0002, 1, 4'b0100, 1, 2, 32'hA5A5_0002));
        tbl.push_back(mk(0, 1, 0, 2, 4'hF, 32'hA5A5_0003, 1, 4'b0100, 1, 2, 32'hA5A5_0003));
        tbl.push_back(mk(0, 1, 0, 2, 4'hF, 32'hA5A5_0004, 1, 4'b0100, 1, 2, 32'hA5A5_0004));
        tbl.push_back(mk(0, 1, 0, 1, 4'h2, 32'h1234_5678, 1, 4'b0010, 1, 1, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 0, 1, 4'h2, 32'h0BAD_0001, 0, 4'b0000, 1, 1, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 0, 1, 4'h2, 32'h0BAD_0001, 0, 4'b0000, 1, 1, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 0, 1, 4'h2, 32'h0BAD_0001, 0, 4'b0000, 1, 1, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 0, 1, 4'h2, 32'h0BAD_0001, 1, 4'b0010, 1, 1, 32'h0BAD_0001));
        tbl.push_back(mk(0, 1, 0, 1, 4'h0, 32'h0000_0000, 1, 4'b0010, 0, 1, 32'h0BAD_0001));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 32'h0000_0000, 0, 4'b0000, 0, 1, 32'h0BAD_0001));
        tbl.push_back(mk(0, 1, 1, 0, 4'h6, 32'h0000_00DD, 0, 4'b0010, 1, 1, 32'h0000_00DD));
        tbl.push_back(mk(0, 0, 1, 0, 4'h6, 32'h0000_00DD, 0, 4'b0000, 0, 0, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'h6, 32'h0000_00EE, 0, 4'b0010, 1, 1, 32'h0000_00EE));
        tbl.push_back(mk(1, 1, 1, 0, 4'h7, 32'h0000_00D1, 1, 4'b0001, 1, 0, 32'h0000_00D1));
        tbl.push_back(mk(1, 1, 1, 0, 4'h7, 32'h0000_00D2, 1, 4'b0010, 1, 1, 32'h0000_00D2));
        tbl.push_back(mk(1, 1, 0, 3, 4'h7, 32'h0000_00D3, 1, 4'b0000, 0, 1, 32'h0000_00D2));
        tbl.push_back(mk(1, 1, 0, 3, 4'h7, 32'h0000_00D4, 0, 4'b0000, 0, 1, 32'h0000_00D2));
        tbl.push_back(mk(1, 1, 1, 0, 4'h7, 32'h0000_00D5, 0, 4'b0100, 1, 2, 32'h0000_00D5));
        tbl.push_back(mk(1, 1, 1, 0, 4'h7, 32'h0000_00D5, 0, 4'b0000, 1, 2, 32'h0000_00D5));
        tbl.push_back(mk(1, 1, 1, 0, 4'h7, 32'h0000_00D7, 1, 4'b0001, 1, 0, 32'h0000_00D7));

        // Reset held for two cycles with every channel valid
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v_mode[d] = 1'b1; v_sel[d] = 2'd0; v_ordy[d] = 1'b0;
            v_vld[d]  = (d == 0) ? 4'hF : 4'h7;
            v_dat[d]  = {4{32'hFFFF_FFFF}};
        end
        push();
        tick();
        #4;
        get_out(0, a_rdy, a_ov, a_src, a_dat);
        chk("reset rdy4", 64'(a_rdy), 64'(4'b0001));
        get_out(1, a_rdy, a_ov, a_src, a_dat);
        chk("reset rdy3", 64'(a_rdy), 64'(4'b0001));
        tick();
        for (int d = 0; d < 2; d++) begin
            get_out(d, a_rdy, a_ov, a_src, a_dat);
            chk($sformatf("reset ov d%0d", d), 64'(a_ov), 64'(1'b0));
            chk($sformatf("reset src d%0d", d), 64'(a_src), 64'(2'd0));
            chk($sformatf("reset dat d%0d", d), 64'(a_dat), 64'(32'd0));
        end

        // N=3 instance idles while the N=4 rows run
        v_mode[1] = 1'b0; v_vld[1] = 4'h0; v_ordy[1] = 1'b1;

        foreach (tbl[i]) begin
            rst_n             = tbl[i].rst_n;
            v_mode[tbl[i].d]  = tbl[i].mode;
            v_sel[tbl[i].d]   = tbl[i].sel;
            v_vld[tbl[i].d]   = tbl[i].vld;
            v_dat[tbl[i].d]   = {4{tbl[i].dat}};
            v_ordy[tbl[i].d]  = tbl[i].ordy;
            push();
            #4;
            get_out(int'(tbl[i].d), a_rdy, a_ov, a_src, a_dat);
            chk($sformatf("row%0d rdy", i), 64'(a_rdy), 64'(tbl[i].x_rdy));
            tick();
            get_out(int'(tbl[i].d), a_rdy, a_ov, a_src, a_dat);
            chk($sformatf("row%0d ov", i), 64'(a_ov), 64'(tbl[i].x_ov));
            chk($sformatf("row%0d src", i), 64'(a_src), 64'(tbl[i].x_src));
            chk($sformatf("row%0d dat", i), 64'(a_dat), 64'(tbl[i].x_dat));
        end

        // Randomized traffic on both instances against the reference model
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            for (int d = 0; d < 2; d++) begin
                v_mode[d] = 1'($urandom_range(0, 1));
                v_sel[d]  = 2'($urandom_range(0, 3));
                v_vld[d]  = 4'($urandom_range(0, 15)) & ((d == 0) ? 4'hF : 4'h7);
                v_ordy[d] = ($urandom_range(0, 9) < 7);
                for (int c = 0; c < 4; c++) v_dat[d][c] = $urandom;
            end
            push();
            #4;
            for (int d = 0; d < 2; d++) begin
                int g;
                logic [3:0] e_rdy;
                model_sel(d, g, e_rdy);
                get_out(d, a_rdy, a_ov, a_src, a_dat);
                chk($sformatf("rnd%0d d%0d rdy", cyc, d), 64'(a_rdy), 64'(e_rdy));
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                get_out(d, a_rdy, a_ov, a_src, a_dat);
                chk($sformatf("rnd%0d d%0d ov", cyc, d), 64'(a_ov), 64'(m_ov[d]));
                chk($sformatf("rnd%0d d%0d src", cyc, d), 64'(a_src), 64'(m_src[d]));
                chk($sformatf("rnd%0d d%0d dat", cyc, d), 64'(a_dat), 64'(m_dat[d]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mux_nx1_reg.md
# mux_nx1_reg

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It replaces the fixed 2:1 32-bit combinational selector wherever the datapath needs a stage boundary, for example write-back source selection or shared memory-port arbitration between fetch and load/store. It has two selection modes: an explicit select, or round-robin arbitration among the valid inputs. The selected word is held in a one-deep output register until the consumer accepts it.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `WIDTH`, default 32: data width in bits, 1..64.
- `SELW`, default 2: select/index width; must satisfy 2^SELW >= N.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data`  in  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N: per-channel valid.
- `in_ready`  out  N: per-channel ready; combinational.
- `mode`  in  1: 0 = explicit select via `sel`; 1 = round-robin.
- `sel`  in  SELW: selected channel in mode 0; ignored in mode 1.
- `out_data`  out  WIDTH: registered selected word.
- `out_src`  out  SELW: index of the channel that supplied `out_data`.
- `out_valid`  out  1: output register holds a word.
- `out_ready`  in  1: consumer accepts the word this cycle.

## Operation
- State:
  - output register (`out_data`, `out_src`, `out_valid`);
  - round-robin pointer `rr_ptr` [SELW-1:0].
- `can_load = !out_valid || out_ready`. The register accepts a new word on the same cycle the old one drains, so there is no bubble.
- Mode 0:
  - `in_ready[i] = can_load && (i == sel)`.
  - A transfer occurs when `in_valid[sel] && in_ready[sel]`.
  - If `sel >= N`, all `in_ready` are 0 and no transfer occurs.
- Mode 1:
  - The grant is the first index g with `in_valid[g]`, scanning circularly from `rr_ptr` (`rr_ptr`, `rr_ptr+1`, ..., wrapping from N-1 to 0).
  - `in_ready[i] = can_load && (i == g) && |in_valid`.
  - On a transfer, `rr_ptr <= (g == N-1) ? 0 : g+1`.
  - With no valid input there is no transfer and `rr_ptr` holds.
- On a transfer: `out_data <= selected in_data`, `out_src <= index`, `out_valid <= 1`.
- With no transfer:
  - if `out_ready && out_valid`, then `out_valid <= 0`, and `out_data`/`out_src` hold their last values;
  - otherwise all outputs hold.
- `rr_ptr` changes only on mode-1 transfers. Mode-0 transfers leave it untouched.
- Mode or `sel` changes take effect on the next accept. A word already in the output register is unaffected.
- At most one `in_ready` bit is high in any cycle.
- Reset, when `rst_n` is low at a clock edge:
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`, `rr_ptr = 0`;
  - a word held in the register is discarded;
  - `in_ready` is combinationally high only for the channel selected by the normal rules, since `out_valid = 0` after reset.

## Timing
- Latency: an input accepted at edge k appears on `out_data`, with `out_valid = 1`, after edge k.
- Throughput: one word per cycle with `out_ready` held high.
- Back-pressure: with `out_valid = 1` and `out_ready = 0`, all `in_ready` are 0, and `out_data`/`out_src` are stable until accepted.
- Input rules:
  - `in_data`/`in_valid` must stay stable while valid and not ready. The block does not check this.
  - In mode 1, `in_ready` depends combinationally on `in_valid`. There is no combinational path from `in_data` to any output.
- Simultaneous drain and load:
  - `out_ready = 1` with a pending transfer replaces the word in the same cycle;
  - `out_valid` stays 1.
- Reset has priority over any transfer in the same cycle.

## Test plan
- Reset: hold `rst_n = 0` for 2 cycles with all `in_valid = 1`.
  - After release: `out_valid = 0`, `out_data = 0`, `out_src = 0`.
  - The first mode-1 transfer comes from channel 0.
- Mode 0 streaming: `sel = 2`, `in_data[2]` = 0xA5A5_0001..0xA5A5_0004 on consecutive cycles, `out_ready = 1`.
  - Outputs appear 1 cycle later, back-to-back, with `out_src = 2`.
  - `in_ready = 4'b0100` throughout.
- Back-pressure: mode 0, `sel = 1`, `out_ready = 0` for 3 cycles after the first word 0x1234_5678.
  - `out_data` stays at 0x1234_5678 and `in_ready = 0`.
  - When `out_ready` rises, the next word loads in that same cycle.
- Round-robin fairness: mode 1, all 4 inputs valid continuously, `out_ready = 1`.
  - `out_src` sequence is 0, 1, 2, 3, 0, 1.
  - With only channels 1 and 3 valid, the sequence is 1, 3, 1, 3.
  - With only channel 3 valid, it is 3, 3, 3 and `rr_ptr` wraps to 0 each time.
- Out-of-range and mode switch: N = 3, mode 0, `sel = 3`.
  - `in_ready = 0` and there is no transfer.
  - Switch to mode 1 mid-stream: `rr_ptr` resumes from its last mode-1 value, and the held output word is unchanged.
- Reset mid-operation: assert `rst_n = 0` while `out_valid = 1` and `out_ready = 0`.
  - Next cycle: `out_valid = 0` and `out_data = 0`.
  - The held word is never delivered.
